// File: rtl/pll_ce_sequencer.sv
// Lock-qualified, phase-aligned clock-enable generator running off the fast PLL clock.
// Channels realign together whenever the PLL requalifies or a new divide/phase set is loaded.
module pll_ce_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    pll_locked,
    input  logic [NUM_CH*CNT_W-1:0] div_cfg,
    input  logic [NUM_CH*CNT_W-1:0] phase_cfg,
    input  logic                    cfg_load,
    output logic                    cfg_busy,
    output logic [NUM_CH-1:0]       ce_out,
    output logic                    ce_sync,
    output logic                    ready
);

    localparam int LCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LCK_W-1:0] LOCK_LAST = LCK_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [1:0] {S_WAIT, S_ALIGN, S_RUN} state_t;

    state_t             state;
    logic               lock_meta;
    logic               lock_s;
    logic [LCK_W-1:0]   lock_cnt;
    logic [CNT_W-1:0]   act_div [NUM_CH];
    logic [CNT_W-1:0]   cnt     [NUM_CH];

    logic [CNT_W-1:0]   a_div   [NUM_CH];
    logic [CNT_W-1:0]   a_ph    [NUM_CH];
    logic [CNT_W-1:0]   a_cnt   [NUM_CH];
    logic [CNT_W-1:0]   e_div   [NUM_CH];
    logic [CNT_W-1:0]   cur_cnt [NUM_CH];
    logic [CNT_W-1:0]   nxt_cnt [NUM_CH];
    logic [NUM_CH-1:0]  hit;

    // A phase at or beyond the period would never fire; pull it back to the last slot.
    function automatic logic [CNT_W-1:0] clamp_phase(input logic [CNT_W-1:0] div,
                                                     input logic [CNT_W-1:0] ph);
        if (div == '0)
            return '0;
        else if (ph >= div)
            return div - ONE;
        else
            return ph;
    endfunction

    // In ALIGN the counters are seeded from the incoming config so that RUN cycle 0 is already correct.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            a_div[i]   = div_cfg[i*CNT_W +: CNT_W];
            a_ph[i]    = clamp_phase(a_div[i], phase_cfg[i*CNT_W +: CNT_W]);
            a_cnt[i]   = (a_div[i] == '0) ? '0 : a_div[i] - ONE - a_ph[i];
            e_div[i]   = (state == S_ALIGN) ? a_div[i] : act_div[i];
            cur_cnt[i] = (state == S_ALIGN) ? a_cnt[i] : cnt[i];
            hit[i]     = (e_div[i] != '0) && (cur_cnt[i] == e_div[i] - ONE);
            if (e_div[i] == '0)
                nxt_cnt[i] = cur_cnt[i];
            else if (hit[i])
                nxt_cnt[i] = '0;
            else
                nxt_cnt[i] = cur_cnt[i] + ONE;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_WAIT;
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            lock_cnt  <= '0;
            cfg_busy  <= 1'b0;
            ce_out    <= '0;
            ce_sync   <= 1'b0;
            ready     <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                act_div[i] <= '0;
                cnt[i]     <= '0;
            end
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
            ce_sync   <= 1'b0;
            case (state)
                S_WAIT: begin
                    ce_out   <= '0;
                    ready    <= 1'b0;
                    cfg_busy <= 1'b0;
                    if (!lock_s) begin
                        lock_cnt <= '0;
                    end else if (lock_cnt == LOCK_LAST) begin
                        lock_cnt <= '0;
                        state    <= S_ALIGN;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                S_ALIGN: begin
                    if (!lock_s) begin
                        state    <= S_WAIT;
                        lock_cnt <= '0;
                        ce_out   <= '0;
                        ready    <= 1'b0;
                        cfg_busy <= 1'b0;
                    end else begin
                        state    <= S_RUN;
                        ready    <= 1'b1;
                        ce_sync  <= 1'b1;
                        cfg_busy <= 1'b0;
                        ce_out   <= hit;
                        for (int i = 0; i < NUM_CH; i++) begin
                            act_div[i] <= a_div[i];
                            cnt[i]     <= nxt_cnt[i];
                        end
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state    <= S_WAIT;
                        lock_cnt <= '0;
                        ce_out   <= '0;
                        ready    <= 1'b0;
                        cfg_busy <= 1'b0;
                    end else if (cfg_busy && (ce_out[0] || act_div[0] == '0)) begin
                        // Reload only at a ch0 boundary so the slowest reference never emits a runt period.
                        state    <= S_ALIGN;
                        ce_out   <= '0;
                        ready    <= 1'b0;
                        cfg_busy <= 1'b0;
                    end else begin
                        ce_out <= hit;
                        for (int i = 0; i < NUM_CH; i++)
                            cnt[i] <= nxt_cnt[i];
                        if (cfg_load)
                            cfg_busy <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_WAIT;
                    lock_cnt <= '0;
                    ce_out   <= '0;
                    ready    <= 1'b0;
                    cfg_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_ce_sequencer.sv
// Scoreboard bench for pll_ce_sequencer: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_pll_ce_sequencer;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int LOCK_C = 16;

    logic                    clk_sys = 1'b0;
    logic                    reset_n;
    logic                    pll_locked;
    logic [NUM_CH*CNT_W-1:0] div_cfg;
    logic [NUM_CH*CNT_W-1:0] phase_cfg;
    logic                    cfg_load;
    logic                    cfg_busy;
    logic [NUM_CH-1:0]       ce_out;
    logic                    ce_sync;
    logic                    ready;

    pll_ce_sequencer #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .LOCK_CYCLES(LOCK_C)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .pll_locked(pll_locked),
        .div_cfg   (div_cfg),
        .phase_cfg (phase_cfg),
        .cfg_load  (cfg_load),
        .cfg_busy  (cfg_busy),
        .ce_out    (ce_out),
        .ce_sync   (ce_sync),
        .ready     (ready)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // div {8,4,2,2} phase {0,0,0,1}: one period of 8 RUN cycles
    localparam logic [3:0] TAB_A [8] = '{4'b0111, 4'b1000, 4'b0100, 4'b1000,
                                         4'b0110, 4'b1000, 4'b0100, 4'b1000};
    // div {6,5,0,1} phase {0,7->4,0,0}: RUN cycles 0..18
    localparam logic [3:0] TAB_B [19] = '{4'b1001, 4'b1000, 4'b1000, 4'b1000, 4'b1010,
                                          4'b1000, 4'b1001, 4'b1000, 4'b1000, 4'b1010,
                                          4'b1000, 4'b1000, 4'b1001, 4'b1000, 4'b1010,
                                          4'b1000, 4'b1000, 4'b1000, 4'b1001};

    int         exp_cyc  [$];
    logic [6:0] exp_val  [$];
    string      exp_name [$];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic expect_at(input int c, input logic [3:0] ce, input logic sync,
                             input logic rdy, input logic busy, input string name);
        exp_cyc.push_back(c);
        exp_val.push_back({ce, sync, rdy, busy});
        exp_name.push_back(name);
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    always @(negedge clk_sys) begin
        while (exp_cyc.size() > 0 && exp_cyc[0] <= cyc) begin
            int         c;
            logic [6:0] w;
            logic [6:0] g;
            string      nm;
            c  = exp_cyc.pop_front();
            w  = exp_val.pop_front();
            nm = exp_name.pop_front();
            g  = {ce_out, ce_sync, ready, cfg_busy};
            n_cmp = n_cmp + 1;
            if (c != cyc || g !== w) begin
                n_bad = n_bad + 1;
                $display("FAIL %s cyc=%0d(want %0d) got ce=%b sync=%b rdy=%b busy=%b required ce=%b sync=%b rdy=%b busy=%b",
                         nm, cyc, c, g[6:3], g[2], g[1], g[0], w[6:3], w[2], w[1], w[0]);
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        pll_locked = 1'b1;
        cfg_load   = 1'b0;
        div_cfg    = {8'd2, 8'd2, 8'd4, 8'd8};
        phase_cfg  = {8'd1, 8'd0, 8'd0, 8'd0};

        expect_at(1, 4'b0000, 1'b0, 1'b0, 1'b0, "reset_state");
        expect_at(2, 4'b0000, 1'b0, 1'b0, 1'b0, "sync_start");
        expect_at(20, 4'b0000, 1'b0, 1'b0, 1'b0, "glitch_restart");
        expect_at(29, 4'b0000, 1'b0, 1'b0, 1'b0, "align_idle");
        for (int k = 0; k <= 8; k++)
            expect_at(30 + k, TAB_A[k % 8], (k == 0), 1'b1, (k >= 4), "run_a");
        expect_at(39, 4'b0000, 1'b0, 1'b0, 1'b0, "realign");

        #12 reset_n = 1'b1;

        goto(10);
        pll_locked = 1'b0;
        goto(11);
        pll_locked = 1'b1;

        goto(33);
        cfg_load  = 1'b1;
        div_cfg   = {8'd1, 8'd0, 8'd5, 8'd6};
        phase_cfg = {8'd0, 8'd0, 8'd7, 8'd0};
        for (int k = 0; k <= 18; k++)
            expect_at(40 + k, TAB_B[k], (k == 0), 1'b1, 1'b0, "run_b");
        expect_at(59, 4'b0000, 1'b0, 1'b0, 1'b0, "lock_loss");
        goto(34);
        cfg_load = 1'b0;

        goto(56);
        pll_locked = 1'b0;

        goto(60);
        cfg_load = 1'b1;
        expect_at(61, 4'b0000, 1'b0, 1'b0, 1'b0, "load_in_wait");
        goto(61);
        cfg_load = 1'b0;

        goto(62);
        pll_locked = 1'b1;
        expect_at(80, 4'b0000, 1'b0, 1'b0, 1'b0, "requal_align");
        for (int k = 0; k <= 3; k++)
            expect_at(81 + k, TAB_B[k], (k == 0), 1'b1, 1'b0, "requal_run");
        expect_at(85, 4'b0000, 1'b0, 1'b0, 1'b0, "async_reset");
        expect_at(86, 4'b0000, 1'b0, 1'b0, 1'b0, "reset_hold");

        goto(85);
        reset_n = 1'b0;
        #1;
        n_cmp = n_cmp + 1;
        if ({ce_out, ce_sync, ready, cfg_busy} !== 7'b0) begin
            n_bad = n_bad + 1;
            $display("FAIL async_reset_immediate got ce=%b sync=%b rdy=%b busy=%b",
                     ce_out, ce_sync, ready, cfg_busy);
        end
        n_cmp = n_cmp + 1;
        if (dut.lock_cnt !== '0) begin
            n_bad = n_bad + 1;
            $display("FAIL async_reset_lock_cnt got %0d", dut.lock_cnt);
        end
        goto(87);
        reset_n = 1'b1;
        expect_at(105, 4'b0000, 1'b0, 1'b0, 1'b0, "post_reset_align");
        expect_at(106, TAB_B[0], 1'b1, 1'b1, 1'b0, "post_reset_run0");
        expect_at(107, TAB_B[1], 1'b0, 1'b1, 1'b0, "post_reset_run1");

        goto(112);
        while (exp_cyc.size() > 0) begin
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL %s never checked: pending cyc=%0d required before cyc=%0d",
                     exp_name[0], exp_cyc[0], cyc);
            void'(exp_cyc.pop_front());
            void'(exp_val.pop_front());
            void'(exp_name.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
